// File: rtl/updown_counter_reg_if.sv
// Control and status bundle of the loadable up/down counter.
// The counter takes the slave side; whatever drives and observes it takes the master side.
interface updown_counter_reg_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             tc;
    logic             zero;

    modport slave (
        input  load, d, en, mode,
        output q, carry, tc, zero
    );

    modport master (
        output load, d, en, mode,
        input  q, carry, tc, zero
    );
endinterface

// File: rtl/updown_counter_reg.sv
// Registered up/down counter with a synchronous parallel load.
// Bound events (overflow when counting up, borrow when counting down) give a
// one-cycle registered carry pulse, which lets counters be cascaded.
// When SATURATE is 0 the count wraps at the bounds. When SATURATE is 1 the
// count holds at the bound, and carry is raised again on every enabled cycle.
module updown_counter_reg #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    updown_counter_reg_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_carry;

    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_up_bound_q;
    logic [WIDTH-1:0] w_down_bound_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_carry_next;

    assign w_at_max = (r_q == MAX_VAL);
    assign w_at_min = (r_q == MIN_VAL);

    // Value taken when a step crosses a bound: wrap to the opposite end, or stay put.
    generate
        if (SATURATE) begin : g_saturate
            assign w_up_bound_q   = MAX_VAL;
            assign w_down_bound_q = MIN_VAL;
        end else begin : g_wrap
            assign w_up_bound_q   = MIN_VAL;
            assign w_down_bound_q = MAX_VAL;
        end
    endgenerate

    // Next count and carry, with Load ahead of En. Reset is handled in the register.
    always_comb begin
        w_q_next     = r_q;
        w_carry_next = 1'b0;
        if (bus.load) begin
            w_q_next = bus.d;
        end else if (bus.en) begin
            if (!bus.mode) begin
                if (w_at_max) begin
                    w_q_next     = w_up_bound_q;
                    w_carry_next = 1'b1;
                end else begin
                    w_q_next = r_q + WIDTH'(1);
                end
            end else begin
                if (w_at_min) begin
                    w_q_next     = w_down_bound_q;
                    w_carry_next = 1'b1;
                end else begin
                    w_q_next = r_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and carry registers. A reset in a counting cycle discards that step.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_q     <= '0;
            r_carry <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_carry <= w_carry_next;
        end
    end

    assign bus.q     = r_q;
    assign bus.carry = r_carry;
    // Terminal count looks one step ahead: high in the cycle before carry rises.
    assign bus.tc    = (!bus.mode && w_at_max) || (bus.mode && w_at_min);
    assign bus.zero  = w_at_min;
endmodule

// File: tb/tb_updown_counter_reg.sv
// Directed bench for updown_counter_reg. It instantiates a wrapping counter and a saturating counter.
module tb_updown_counter_reg;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    updown_counter_reg_if #(.WIDTH(4)) bus_wrap ();
    updown_counter_reg_if #(.WIDTH(4)) bus_sat ();

    updown_counter_reg #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_wrap.slave)
    );

    updown_counter_reg #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_sat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advances one rising edge, then waits until the registered outputs have settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wrap(input logic load, input logic [3:0] d, input logic en, input logic mode);
        bus_wrap.load = load;
        bus_wrap.d    = d;
        bus_wrap.en   = en;
        bus_wrap.mode = mode;
    endtask

    task automatic drive_sat(input logic load, input logic [3:0] d, input logic en, input logic mode);
        bus_sat.load = load;
        bus_sat.d    = d;
        bus_sat.en   = en;
        bus_sat.mode = mode;
    endtask

    initial begin
        logic [3:0] exp_q;
        logic [3:0] down_seq [5];
        n_checks = 0;
        n_errors = 0;
        down_seq = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};

        // Reset state.
        rst = 1'b1;
        drive_wrap(1'b0, 4'h0, 1'b1, 1'b0);
        drive_sat(1'b0, 4'h0, 1'b0, 1'b0);
        step();
        step();
        check_val("reset_q", bus_wrap.q, 4'h0);
        check_val("reset_carry", bus_wrap.carry, 1'b0);
        check_val("reset_zero", bus_wrap.zero, 1'b1);
        check_val("reset_tc_up", bus_wrap.tc, 1'b0);
        check_val("reset_sat_q", bus_sat.q, 4'h0);
        $display("txn reset: q=%0h carry=%0b", bus_wrap.q, bus_wrap.carry);

        // Count up for 18 cycles through the wrap.
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            step();
            exp_q = 4'(i % 16);
            check_val($sformatf("up_q[%0d]", i), bus_wrap.q, exp_q);
            check_val($sformatf("up_carry[%0d]", i), bus_wrap.carry, (i == 16) ? 1 : 0);
            check_val($sformatf("up_tc[%0d]", i), bus_wrap.tc, (exp_q == 4'hF) ? 1 : 0);
            $display("txn up %0d: q=%0h carry=%0b tc=%0b", i, bus_wrap.q, bus_wrap.carry, bus_wrap.tc);
        end

        // Hold while En is low.
        drive_wrap(1'b0, 4'h0, 1'b0, 1'b0);
        step();
        check_val("hold_q", bus_wrap.q, 4'h2);
        check_val("hold_carry", bus_wrap.carry, 1'b0);
        $display("txn hold: q=%0h", bus_wrap.q);

        // Load 3, then count down 5 cycles through the borrow.
        drive_wrap(1'b1, 4'h3, 1'b1, 1'b1);
        step();
        check_val("load3_q", bus_wrap.q, 4'h3);
        check_val("load3_carry", bus_wrap.carry, 1'b0);
        drive_wrap(1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("down_tc_pre[%0d]", i), bus_wrap.tc, (i == 3) ? 1 : 0);
            step();
            check_val($sformatf("down_q[%0d]", i), bus_wrap.q, down_seq[i]);
            check_val($sformatf("down_carry[%0d]", i), bus_wrap.carry, (i == 3) ? 1 : 0);
            check_val($sformatf("down_zero[%0d]", i), bus_wrap.zero, (down_seq[i] == 4'h0) ? 1 : 0);
            $display("txn down %0d: q=%0h carry=%0b zero=%0b", i, bus_wrap.q, bus_wrap.carry, bus_wrap.zero);
        end

        // Load with En at Q=F: the load wins and no overflow pulse is produced.
        drive_wrap(1'b1, 4'hF, 1'b0, 1'b0);
        step();
        check_val("loadF_tc", bus_wrap.tc, 1'b1);
        drive_wrap(1'b1, 4'h5, 1'b1, 1'b0);
        step();
        check_val("load_wins_q", bus_wrap.q, 4'h5);
        check_val("load_wins_carry", bus_wrap.carry, 1'b0);
        $display("txn load_over_en: q=%0h carry=%0b", bus_wrap.q, bus_wrap.carry);

        // Reset while counting up from 7 discards both the step and the load.
        drive_wrap(1'b1, 4'h7, 1'b0, 1'b0);
        step();
        drive_wrap(1'b0, 4'h0, 1'b1, 1'b0);
        step();
        check_val("pre_reset_q", bus_wrap.q, 4'h8);
        rst = 1'b1;
        drive_wrap(1'b1, 4'hA, 1'b1, 1'b0);
        step();
        check_val("mid_reset_q", bus_wrap.q, 4'h0);
        check_val("mid_reset_carry", bus_wrap.carry, 1'b0);
        rst = 1'b0;
        drive_wrap(1'b0, 4'h0, 1'b1, 1'b0);
        step();
        check_val("post_reset_q", bus_wrap.q, 4'h1);
        $display("txn mid_reset: q=%0h", bus_wrap.q);

        // Toggle Mode on every cycle, starting from 8.
        drive_wrap(1'b1, 4'h8, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive_wrap(1'b0, 4'h0, 1'b1, 1'(i % 2));
            step();
            check_val($sformatf("toggle_q[%0d]", i), bus_wrap.q, (i % 2 == 0) ? 4'h9 : 4'h8);
            check_val($sformatf("toggle_carry[%0d]", i), bus_wrap.carry, 1'b0);
            check_val($sformatf("toggle_tc[%0d]", i), bus_wrap.tc, 1'b0);
            $display("txn toggle %0d: q=%0h carry=%0b", i, bus_wrap.q, bus_wrap.carry);
        end
        drive_wrap(1'b0, 4'h0, 1'b0, 1'b0);

        // Saturating counter, upward: load E, then 4 enabled up steps.
        drive_sat(1'b1, 4'hE, 1'b0, 1'b0);
        step();
        check_val("sat_load_q", bus_sat.q, 4'hE);
        drive_sat(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("sat_up_q[%0d]", i), bus_sat.q, 4'hF);
            check_val($sformatf("sat_up_carry[%0d]", i), bus_sat.carry, (i == 0) ? 0 : 1);
            check_val($sformatf("sat_up_tc[%0d]", i), bus_sat.tc, 1'b1);
            $display("txn sat_up %0d: q=%0h carry=%0b", i, bus_sat.q, bus_sat.carry);
        end
        drive_sat(1'b0, 4'h0, 1'b0, 1'b0);
        step();
        check_val("sat_idle_carry", bus_sat.carry, 1'b0);

        // Saturating counter, downward: load 1, then 3 enabled down steps.
        drive_sat(1'b1, 4'h1, 1'b0, 1'b1);
        step();
        drive_sat(1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("sat_down_q[%0d]", i), bus_sat.q, 4'h0);
            check_val($sformatf("sat_down_carry[%0d]", i), bus_sat.carry, (i == 0) ? 0 : 1);
            check_val($sformatf("sat_down_zero[%0d]", i), bus_sat.zero, 1'b1);
            $display("txn sat_down %0d: q=%0h carry=%0b", i, bus_sat.q, bus_sat.carry);
        end
        drive_sat(1'b0, 4'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
